// File: rtl/synth_pkg.sv
// synth_pkg: shared note table, octave constant and helpers for the key period tracker
package synth_pkg;
    localparam int BASE_OCTAVE = 4;
    localparam int TABLE_W = 8;
    localparam int NUM_NOTES = 12;
    localparam logic [TABLE_W-1:0] BASE_TABLE [NUM_NOTES] = '{
        8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69, 8'd65, 8'd61, 8'd58, 8'd55, 8'd51, 8'd49
    };
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } sel_t;
    function automatic logic [TABLE_W-1:0] base_period(input logic [3:0] idx);
        return idx < 4'(NUM_NOTES) ? BASE_TABLE[idx] : '0;
    endfunction
    function automatic logic [31:0] scale_period(input logic [TABLE_W-1:0] base, input logic [2:0] octave);
        return octave < 3'(BASE_OCTAVE) ? 32'(base) << (3'(BASE_OCTAVE) - octave)
                                        : 32'(base) >> (octave - 3'(BASE_OCTAVE));
    endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser followed by a consecutive-cycle debounce filter
module key_debouncer
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic db
);
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYC - 1);
    logic [1:0]  sync;
    logic [15:0] cnt;
    // Synchronise, then accept a change only after it has persisted DEBOUNCE_CYC cycles
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], key};
            cnt  <= (sync[1] != db && cnt != LAST) ? cnt + 16'd1 : 16'd0;
            if (sync[1] != db && cnt == LAST) db <= sync[1];
        end
endmodule

// File: rtl/key_period_tracker.sv
// key_period_tracker: debounces keys, picks one by priority mode and outputs its octave-scaled half-period
module key_period_tracker
    import synth_pkg::*;
#(
    parameter int NUM_KEYS     = 12,
    parameter int PERIOD_W     = 12,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [2:0]          octave,
    input  logic                prio_mode,
    output logic [PERIOD_W-1:0] half_period,
    output logic                note_valid,
    output logic [3:0]          note_idx,
    output logic                note_change
);
    logic [NUM_KEYS-1:0] db, db_q, press;
    logic [15:0]         db_w;
    logic [3:0]          low_held, low_press;
    logic                any_held, any_press;
    logic [31:0]         scaled;
    logic [PERIOD_W-1:0] hp_next;
    sel_t                sel, sel_next;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk (clk),
            .rst (rst),
            .key (keys[i]),
            .db  (db[i])
        );
    end

    assign press = db & ~db_q;
    assign db_w  = 16'(db);

    // Lowest-index held key and lowest-index newly pressed key
    always_comb begin
        {any_held, low_held, any_press, low_press} = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (db[i]) {any_held, low_held} = {1'b1, 4'(i)};
            if (press[i]) {any_press, low_press} = {1'b1, 4'(i)};
        end
    end

    // Mode 0 tracks the lowest held key; mode 1 follows presses and falls back on release of the selection
    always_comb
        sel_next = !prio_mode                  ? sel_t'({any_held, low_held}) :
                   any_press                   ? sel_t'({1'b1, low_press}) :
                   (sel.valid && !db_w[sel.idx]) ? sel_t'({any_held, low_held}) : sel;

    assign scaled  = sel.valid ? scale_period(base_period(sel.idx), octave) : 32'd0;
    assign hp_next = (scaled >> PERIOD_W) != 32'd0 ? '1 : PERIOD_W'(scaled);

    // Edge history, selection and registered outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            db_q        <= '0;
            sel         <= '0;
            half_period <= '0;
            note_valid  <= 1'b0;
            note_idx    <= '0;
            note_change <= 1'b0;
        end else begin
            db_q        <= db;
            sel         <= sel_next;
            half_period <= hp_next;
            note_valid  <= sel.valid;
            note_idx    <= sel.valid ? sel.idx : 4'd0;
            note_change <= hp_next != half_period;
        end
endmodule

// File: tb/tb_key_period_tracker.sv
// tb_key_period_tracker: directed scenarios checked against a behavioural model every cycle
module tb_key_period_tracker;
    localparam int D = 4;
    logic        clk = 1'b0, rst = 1'b1, prio_mode = 1'b0;
    logic [11:0] keys = '0;
    logic [2:0]  octave = 3'd4;
    logic [11:0] hp;
    logic [7:0]  hp8;
    logic        nv, nc, nv8, nc8;
    logic [3:0]  ni, ni8;
    int          checks = 0, fails = 0, pulses = 0, p0;
    int          base_tab [12] = '{92, 87, 82, 77, 73, 69, 65, 61, 58, 55, 51, 49};
    logic [11:0] rh [D + 2];
    logic [11:0] mdb = '0, mdbp = '0;
    bit          msv = 0, mnv = 0, mnc = 0, mnc8 = 0;
    int          msi = 0, mhp = 0, mhp8 = 0, mni = 0;

    always #5 clk = ~clk;

    key_period_tracker dut (
        .clk(clk), .rst(rst), .keys(keys), .octave(octave), .prio_mode(prio_mode),
        .half_period(hp), .note_valid(nv), .note_idx(ni), .note_change(nc)
    );
    key_period_tracker #(.PERIOD_W(8)) dut8 (
        .clk(clk), .rst(rst), .keys(keys), .octave(octave), .prio_mode(prio_mode),
        .half_period(hp8), .note_valid(nv8), .note_idx(ni8), .note_change(nc8)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [11:0] v);
        for (int i = 0; i < 12; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int note_period(input int idx, input int oct, input int w);
        int v;
        v = oct < 4 ? base_tab[idx] * (1 << (4 - oct)) : base_tab[idx] / (1 << (oct - 4));
        return v > (1 << w) - 1 ? (1 << w) - 1 : v;
    endfunction

    task automatic model_step();
        int h, p, v;
        bit flip;
        if (rst) begin
            for (int k = 0; k < D + 2; k++) rh[k] = '0;
            {mdb, mdbp} = '0;
            {msv, mnv, mnc, mnc8} = '0;
            {msi, mhp, mhp8, mni} = '0;
            return;
        end
        v = msv ? note_period(msi, octave, 12) : 0;
        mnc = v != mhp;
        mhp = v;
        v = msv ? note_period(msi, octave, 8) : 0;
        mnc8 = v != mhp8;
        mhp8 = v;
        mnv = msv;
        mni = msv ? msi : 0;
        h = lowest(mdb);
        p = lowest(mdb & ~mdbp);
        if (prio_mode && p >= 0) begin
            msv = 1;
            msi = p;
        end else if (!prio_mode || (msv && !mdb[msi])) begin
            msv = h >= 0;
            msi = h >= 0 ? h : 0;
        end
        mdbp = mdb;
        for (int k = D + 1; k > 0; k--) rh[k] = rh[k - 1];
        rh[0] = keys;
        for (int i = 0; i < 12; i++) begin
            flip = 1;
            for (int k = 2; k <= D + 1; k++) if (rh[k][i] == mdb[i]) flip = 0;
            if (flip) mdb[i] = ~mdb[i];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("m_half_period", hp, rst ? 0 : mhp);
        check("m_note_valid", nv, rst ? 0 : mnv);
        check("m_note_idx", ni, rst ? 0 : mni);
        check("m_note_change", nc, rst ? 0 : mnc);
        check("m8_half_period", hp8, rst ? 0 : mhp8);
        check("m8_note_valid", nv8, rst ? 0 : mnv);
        check("m8_note_idx", ni8, rst ? 0 : mni);
        check("m8_note_change", nc8, rst ? 0 : mnc8);
        if (nc) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        tick(3);
        check("reset_hp", hp, 0);
        check("reset_valid", nv, 0);
        check("reset_change", nc, 0);
        rst = 1'b0;
        p0 = pulses;
        keys[9] = 1'b1;
        tick(7);
        check("k9_before_latency", hp, 0);
        tick(1);
        check("k9_hp", hp, 55);
        check("k9_idx", ni, 9);
        check("k9_valid", nv, 1);
        check("k9_change", nc, 1);
        tick(1);
        check("k9_change_drop", nc, 0);
        check("k9_pulses", pulses - p0, 1);
        keys = '0;
        tick(10);
        check("k9_release", hp, 0);
        p0 = pulses;
        keys[0] = 1'b1;
        tick(2);
        keys = '0;
        tick(10);
        check("glitch_hp", hp, 0);
        check("glitch_pulses", pulses - p0, 0);
        keys[0] = 1'b1;
        tick(8);
        check("k0_hp", hp, 92);
        octave = 3'd0;
        tick(1);
        check("oct0_hp", hp, 1472);
        check("oct0_hp8", hp8, 255);
        check("oct0_change", nc, 1);
        octave = 3'd7;
        tick(1);
        check("oct7_hp", hp, 11);
        check("oct7_hp8", hp8, 11);
        check("oct7_change", nc, 1);
        octave = 3'd2;
        tick(1);
        check("oct2_hp", hp, 368);
        check("oct2_hp8", hp8, 255);
        check("oct2_change8", nc8, 1);
        octave = 3'd4;
        tick(1);
        check("oct4_hp", hp, 92);
        check("oct4_change", nc, 1);
        tick(1);
        check("oct_settle_change", nc, 0);
        keys = '0;
        tick(10);
        prio_mode = 1'b1;
        keys[0] = 1'b1;
        tick(10);
        check("p1_k0", hp, 92);
        keys[7] = 1'b1;
        tick(10);
        check("p1_k7", hp, 61);
        check("p1_k7_idx", ni, 7);
        keys[7] = 1'b0;
        tick(10);
        check("p1_fallback", hp, 92);
        keys[0] = 1'b0;
        tick(10);
        check("p1_idle_hp", hp, 0);
        check("p1_idle_valid", nv, 0);
        prio_mode = 1'b0;
        keys[0] = 1'b1;
        tick(10);
        check("p0_k0", hp, 92);
        keys[7] = 1'b1;
        tick(10);
        check("p0_k0_held", hp, 92);
        keys[0] = 1'b0;
        tick(10);
        check("p0_k7", hp, 61);
        keys = '0;
        tick(10);
        check("p0_idle", hp, 0);
        keys[3] = 1'b1;
        tick(10);
        check("k3_hp", hp, 77);
        #1 rst = 1'b1;
        #1;
        check("async_rst_hp", hp, 0);
        check("async_rst_valid", nv, 0);
        check("async_rst_idx", ni, 0);
        tick(2);
        rst = 1'b0;
        tick(7);
        check("post_rst_wait", hp, 0);
        tick(1);
        check("post_rst_hp", hp, 77);
        check("post_rst_valid", nv, 1);
        prio_mode = 1'b1;
        tick(5);
        check("mode_switch_keeps", ni, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/key_period_tracker.md
KEY_PERIOD_TRACKER -- requirements
Module: key_period_tracker

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12, meaning number of key inputs (legal 1..12; key 0 = C4 through key 11 = B4).
REQ-002 SHALL have parameter PERIOD_W, default 12, meaning width of the half_period output.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 4, meaning consecutive stable cycles required to accept a key change (legal 1..65535).
REQ-004 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port keys  input  NUM_KEYS  meaning raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have port octave  input  3  meaning octave select 0..7, where 4 = base octave (C4..B4).
REQ-008 SHALL have port prio_mode  input  1  meaning 0 = lowest-index priority, 1 = last-pressed priority.
REQ-009 SHALL have port half_period  output  PERIOD_W  meaning selected note half-period in 48 kHz sample ticks, 0 when idle.
REQ-010 SHALL have port note_valid  output  1  meaning a key is selected.
REQ-011 SHALL have port note_idx  output  4  meaning index of the selected key, 0 when idle.
REQ-012 SHALL have port note_change  output  1  meaning one-cycle pulse whenever half_period changes value.

Function
REQ-013 SHALL pass each keys bit through a 2-flop synchroniser before any other use.
REQ-014 SHALL keep a debounced state db[i] per key; db[i] takes the synchronised value only after it has differed from db[i] for DEBOUNCE_CYC consecutive cycles; any cycle of agreement clears the counter.
REQ-015 SHALL detect press events as db[i] rising (0->1) and release events as db[i] falling, one cycle after the db update.
REQ-016 In prio_mode 0 SHALL select the lowest index i with db[i]=1, re-evaluated every cycle.
REQ-017 In prio_mode 1 SHALL select a newly pressed key on its press event; for simultaneous presses, the lowest index among them.
REQ-018 In prio_mode 1 SHALL, when the selected key is released with no press that cycle, fall back to the lowest-index held key, or idle if none.
REQ-019 In prio_mode 1 SHALL hold the current selection while other keys are pressed-and-held or released.
REQ-020 SHALL apply a prio_mode change on the next cycle without clearing state; switching 0->1 keeps the current selection.
REQ-021 SHALL look up the base half-period from the table 92,87,82,77,73,69,65,61,58,55,51,49 for index 0..11.
REQ-022 SHALL scale base by octave: octave<4 -> base << (4-octave); octave>4 -> base >> (octave-4) (truncating); octave=4 -> base.
REQ-023 SHALL saturate half_period to all-ones when the shifted value exceeds PERIOD_W bits.
REQ-024 SHALL register half_period, note_valid and note_idx; they update 1 cycle after the selection/octave changes (raw key to output: 2 + DEBOUNCE_CYC + 2 cycles).
REQ-025 SHALL drive idle as half_period=0, note_valid=0, note_idx=0.
REQ-026 SHALL assert note_change for exactly the cycle in which registered half_period differs from its previous value, including octave changes and transitions to or from idle.

Reset
REQ-027 SHALL on rst clear synchronisers, db, debounce counters and selection, drive half_period=0, note_valid=0, note_idx=0 and note_change=0, asynchronously.
REQ-028 SHALL, on a reset asserted mid-press, treat keys held at deassertion as new presses once debounced, not as already pressed.

Structure
REQ-029 SHALL place the 12-entry base half-period table, the base-octave constant (4) and the legacy 8-bit table width in a shared package synth_pkg.
REQ-030 SHALL implement per-key synchroniser plus debounce as sub-module key_debouncer, instantiated NUM_KEYS times.

Verification
REQ-031 Bench SHALL cover: key 9 held, octave=4, DEBOUNCE_CYC=4 -> half_period=55, note_idx=9, note_valid=1 at cycle 8 after press, with one note_change pulse.
REQ-032 Bench SHALL cover: key 0 with a 2-cycle glitch -> no output change; held 4+ cycles -> half_period=92.
REQ-033 Bench SHALL cover: prio_mode 1, hold key 0 then press key 7 -> 61; release key 7 -> 92; release key 0 -> 0, note_valid=0.
REQ-034 Bench SHALL cover: prio_mode 0, same sequence -> half_period stays 92 until key 0 is released, then 61.
REQ-035 Bench SHALL cover octave scaling with key 0 held: octave 0 -> 1472, octave 7 -> 11; PERIOD_W=8, octave 2 -> 255 saturated; a note_change pulse on each change.
REQ-036 Bench SHALL cover: rst asserted while key 3 is selected -> outputs 0 immediately; key still held after release -> 77 after the full debounce latency.
